exp_approx_pipe: RTL

EXP_APPROX_PIPE -- requirements
Module: exp_approx_pipe

---
 rtl/exp_approx_pipe.sv | 102 ++++++++++
 1 files changed

// File: rtl/exp_approx_pipe.sv
// Three-stage e^x approximation on signed Q4.12 operands (scale by log2(e), split, shift/saturate).
// Latency 3 cycles, 1/cycle; a single global advance stalls every stage while the output is held.
module exp_approx_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_x,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] exp_x,
    output logic        out_sat,
    output logic        out_valid,
    input  logic        out_ready
);

    logic               en;

    logic               s1_vld_q;
    logic signed [17:0] s1_t_q;
    logic signed [17:0] s1_t_d;

    logic               s2_vld_q;
    logic signed [4:0]  s2_k_q;
    logic signed [4:0]  s2_k_d;
    logic [12:0]        s2_m_q;
    logic [12:0]        s2_m_d;

    logic               s3_vld_q;
    logic [15:0]        s3_exp_q;
    logic [15:0]        s3_exp_d;
    logic               s3_sat_q;
    logic               s3_sat_d;

    logic signed [29:0] x_ext;
    logic signed [29:0] s1_prod;
    logic [15:0]        m_ext;
    logic [4:0]         neg_k;
    logic               unused_bits;

    assign en       = !s3_vld_q || out_ready;
    assign in_ready = en;

    // x * log2(e) in Q4.12; the product never exceeds 29 signed bits.
    assign x_ext   = {{14{in_x[15]}}, in_x};
    assign s1_prod = x_ext * 30'sd5909;
    assign s1_t_d  = s1_prod[29:12];

    // Slicing above bit 12 is the floor of t/4096; the fraction is the low 12 bits.
    assign s2_k_d = s1_t_q[16:12];
    assign s2_m_d = {1'b1, s1_t_q[11:0]};

    assign m_ext = {3'b000, s2_m_q};
    assign neg_k = 5'd0 - s2_k_q;

    always_comb begin
        s3_exp_d = 16'h0000;
        s3_sat_d = 1'b0;
        if (s2_k_q >= 5'sd3) begin
            s3_exp_d = 16'h7FFF;
            s3_sat_d = 1'b1;
        end else if (s2_k_q >= 5'sd0) begin
            s3_exp_d = m_ext << s2_k_q[1:0];
        end else if (s2_k_q >= -5'sd12) begin
            s3_exp_d = m_ext >> neg_k[3:0];
        end
    end

    assign unused_bits = ^{s1_prod[11:0], s1_t_q[17], neg_k[4]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_t_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_k_q   <= '0;
            s2_m_q   <= '0;
            s3_vld_q <= 1'b0;
            s3_exp_q <= 16'h0000;
            s3_sat_q <= 1'b0;
        end else if (en) begin
            s1_vld_q <= in_valid;
            s2_vld_q <= s1_vld_q;
            s3_vld_q <= s2_vld_q;
            // Data registers only move with a real operand; bubbles leave them untouched.
            if (in_valid) begin
                s1_t_q <= s1_t_d;
            end
            if (s1_vld_q) begin
                s2_k_q <= s2_k_d;
                s2_m_q <= s2_m_d;
            end
            if (s2_vld_q) begin
                s3_exp_q <= s3_exp_d;
                s3_sat_q <= s3_sat_d;
            end
        end
    end

    assign exp_x     = s3_exp_q;
    assign out_sat   = s3_sat_q;
    assign out_valid = s3_vld_q;

endmodule
